// File: rtl/host_iface_pkg.sv
// host_iface_pkg: shared constants for multiplexer clients of host_iface.
package host_iface_pkg;
  localparam int REC_BYTES_DEF = 6;
  localparam int LOST_CNT_W = 16;
  localparam bit MSB_FIRST = 1'b1;
endpackage

// File: rtl/omux_record_writer_if.sv
// omux_record_writer_if: request/select/data slot between a client and the output multiplexer.
interface omux_record_writer_if;
  logic req;
  logic sel;
  logic [7:0] data;
  modport master (output req, output data, input sel);
  modport slave (input req, input data, output sel);
endinterface

// File: rtl/omux_record_writer_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read and an extra fill bit for full/empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = fill == (AW+1)'(DEPTH);
  assign empty = fill == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wp <= '0;
      rp <= '0;
      fill <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      fill <= fill + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // Storage is deliberately unreset; pointers alone define contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wp] <= wdata;
  end
endmodule

// File: rtl/omux_record_writer.sv
// omux_record_writer: buffers fixed-width records and streams them byte-wise into one output multiplexer slot.
module omux_record_writer
  import host_iface_pkg::*;
#(
  parameter int REC_BYTES  = REC_BYTES_DEF,
  parameter int DEPTH      = 16,
  parameter int BURST_RECS = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [REC_BYTES*8-1:0] rec_i,
  input  logic                   rec_valid_i,
  omux_record_writer_if.master   omux,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic                   full_o,
  output logic [LOST_CNT_W-1:0]  lost_count_o,
  input  logic                   lost_clr_i
);
  localparam int IW = REC_BYTES > 1 ? $clog2(REC_BYTES) : 1;
  localparam int BW = BURST_RECS > 0 ? $clog2(BURST_RECS + 1) : 1;
  localparam logic [IW-1:0] ILAST = IW'(REC_BYTES - 1);
  localparam logic [BW-1:0] BLAST = BW'(BURST_RECS > 0 ? BURST_RECS - 1 : 0);
  logic [REC_BYTES*8-1:0] head, shifted;
  logic [IW-1:0] idx, pos;
  logic [BW-1:0] burst_cnt;
  logic yield_q, empty, consume, last, pop, hit;
  sync_fifo #(.WIDTH(REC_BYTES*8), .DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push     (rec_valid_i),
    .pop      (pop),
    .wdata    (rec_i),
    .rdata    (head),
    .fill     (fill_o),
    .full     (full_o),
    .empty    (empty)
  );
  assign omux.req = !empty && !yield_q;
  assign consume = omux.sel && omux.req;
  assign last = idx == ILAST;
  assign pop = consume && last;
  assign hit = pop && BURST_RECS != 0 && burst_cnt == BLAST;
  assign pos = MSB_FIRST ? ILAST - idx : idx;
  assign shifted = head >> {pos, 3'b000};
  // Gated so the data bus reads 0 whenever nothing is offered, including in reset.
  assign omux.data = omux.req ? shifted[7:0] : 8'h00;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      idx <= '0;
      burst_cnt <= '0;
      yield_q <= 1'b0;
      lost_count_o <= '0;
    end else begin
      if (consume) idx <= last ? '0 : idx + IW'(1);
      burst_cnt <= !omux.req || hit ? '0 : pop ? burst_cnt + BW'(1) : burst_cnt;
      // A select seen while yielding is the multiplexer's release cycle.
      yield_q <= hit || (yield_q && !empty && !omux.sel);
      lost_count_o <= lost_clr_i ? '0 :
                      rec_valid_i && full_o && lost_count_o != '1 ? lost_count_o + LOST_CNT_W'(1) :
                      lost_count_o;
    end
  end
endmodule

// File: tb/tb_omux_record_writer.sv
// tb_omux_record_writer: directed bench for omux_record_writer with a small multiplexer model.
module tb_omux_record_writer;
  localparam int RB = 6;
  localparam int D = 16;
  localparam int BR = 2;
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  logic [RB*8-1:0] rec_i = '0;
  logic rec_valid_i = 1'b0;
  logic lost_clr_i = 1'b0;
  logic [4:0] fill_o;
  logic full_o;
  logic [15:0] lost_count_o;
  logic [7:0] b;
  int checks = 0;
  int errors = 0;
  omux_record_writer_if omux ();
  omux_record_writer #(.REC_BYTES(RB), .DEPTH(D), .BURST_RECS(BR)) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .rec_i        (rec_i),
    .rec_valid_i  (rec_valid_i),
    .omux         (omux),
    .fill_o       (fill_o),
    .full_o       (full_o),
    .lost_count_o (lost_count_o),
    .lost_clr_i   (lost_clr_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [47:0] mk_rec(input int k);
    logic [47:0] r;
    for (int j = 0; j < RB; j++) r[47-8*j -: 8] = 8'(k * 8 + j);
    return r;
  endfunction
  function automatic logic [7:0] rec_byte(input int k, input int j);
    return 8'(k * 8 + j);
  endfunction
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic push(input logic [47:0] r);
    rec_i = r;
    rec_valid_i = 1'b1;
    tick();
    rec_valid_i = 1'b0;
  endtask
  // Multiplexer model: grants one byte, releasing a yielded client when it sees one.
  task automatic get_byte(output logic [7:0] v);
    bit done = 0;
    v = 8'hxx;
    for (int c = 0; c < 40 && !done; c++) begin
      if (omux.req) begin
        v = omux.data;
        omux.sel = 1'b1;
        tick();
        omux.sel = 1'b0;
        done = 1;
      end else if (fill_o != 0) begin
        omux.sel = 1'b1;
        tick();
        omux.sel = 1'b0;
      end else tick();
    end
    if (!done) check("mux_timeout", 48'(done), 48'd1);
  endtask
  initial begin
    omux.sel = 1'b0;
    repeat (2) tick();
    check("rst_req", omux.req, 0);
    check("rst_data", omux.data, 0);
    check("rst_fill", fill_o, 0);
    check("rst_full", full_o, 0);
    check("rst_lost", lost_count_o, 0);
    reset_ni = 1'b1;
    tick();
    push(48'h010203040506);
    check("t1_fill", fill_o, 1);
    check("t1_req", omux.req, 1);
    for (int i = 0; i < 6; i++) begin
      get_byte(b);
      check("t1_byte", b, 48'(i + 1));
      if (i == 4) check("t1_req_mid", omux.req, 1);
      if (i == 5) begin
        check("t1_req_fall", omux.req, 0);
        check("t1_fill_end", fill_o, 0);
      end
      repeat (2) tick();
    end
    for (int k = 0; k < 20; k++) begin
      push(mk_rec(k));
      if (k == 15) begin
        check("t2_full", full_o, 1);
        check("t2_fill16", fill_o, 16);
      end
    end
    check("t2_lost", lost_count_o, 4);
    check("t2_fill", fill_o, 16);
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < RB; j++) begin
        get_byte(b);
        check("t2_drain", b, rec_byte(k, j));
      end
    check("t2_empty", fill_o, 0);
    for (int k = 0; k < 16; k++) push(mk_rec(k));
    for (int j = 0; j < RB - 1; j++) get_byte(b);
    check("t3_last_byte", omux.data, rec_byte(0, 5));
    rec_i = mk_rec(99);
    rec_valid_i = 1'b1;
    omux.sel = 1'b1;
    tick();
    rec_valid_i = 1'b0;
    omux.sel = 1'b0;
    check("t3_fill", fill_o, 15);
    check("t3_lost", lost_count_o, 5);
    check("t3_full", full_o, 0);
    for (int k = 1; k < 16; k++)
      for (int j = 0; j < RB; j++) begin
        get_byte(b);
        check("t3_drain", b, rec_byte(k, j));
      end
    check("t3_empty", fill_o, 0);
    for (int k = 0; k < 5; k++) push(mk_rec(40 + k));
    for (int n = 0; n < 30; n++) begin
      get_byte(b);
      check("t4_byte", b, rec_byte(40 + n / RB, n % RB));
      if (n == 11 || n == 23) begin
        check("t4_req_drop", omux.req, 0);
        check("t4_fill", fill_o, n == 11 ? 3 : 1);
        tick();
        check("t4_req_hold", omux.req, 0);
        omux.sel = 1'b1;
        tick();
        omux.sel = 1'b0;
        check("t4_req_back", omux.req, 1);
      end
    end
    check("t4_req_end", omux.req, 0);
    check("t4_empty", fill_o, 0);
    push(mk_rec(50));
    for (int j = 0; j < 3; j++) get_byte(b);
    #2 reset_ni = 1'b0;
    #1;
    check("t5_req", omux.req, 0);
    check("t5_data", omux.data, 0);
    check("t5_fill", fill_o, 0);
    check("t5_full", full_o, 0);
    check("t5_lost", lost_count_o, 0);
    tick();
    reset_ni = 1'b1;
    repeat (3) tick();
    check("t5_idle_req", omux.req, 0);
    push(mk_rec(51));
    for (int j = 0; j < RB; j++) begin
      get_byte(b);
      check("t5_byte", b, rec_byte(51, j));
    end
    for (int k = 0; k < 16; k++) push(mk_rec(k));
    check("t6_full", full_o, 1);
    rec_valid_i = 1'b1;
    repeat (65534) tick();
    check("t6_fffe", lost_count_o, 16'hFFFE);
    tick();
    check("t6_ffff", lost_count_o, 16'hFFFF);
    tick();
    check("t6_sat", lost_count_o, 16'hFFFF);
    lost_clr_i = 1'b1;
    tick();
    lost_clr_i = 1'b0;
    rec_valid_i = 1'b0;
    check("t6_clr", lost_count_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/omux_record_writer.md
Name: omux_record_writer

Overview:
- Client-side writer for the output multiplexer's request/select/data protocol: buffers fixed-width event records from the tagger core and streams them byte-wise into the multiplexer toward the FT2232.
- One instance per data source, sitting between the tagger record producer and one omux_req/omux_sel/omux_data slot of host_iface.
- Provides overflow accounting and bounded burst length, so the register manager and other sources are not starved.

Parameters:
- REC_BYTES, 6, bytes per record. Legal range 1..16.
- DEPTH, 16, FIFO depth in records. Must be a power of 2, at least 2.
- BURST_RECS, 8, maximum records sent per multiplexer grant before yielding. 0 means unlimited.

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  asynchronous, active-low reset
- rec_i  in  REC_BYTES*8  record to enqueue. Byte 0 is bits [8*REC_BYTES-1 -: 8] (MSB first).
- rec_valid_i  in  1  one-cycle strobe that enqueues rec_i. There is no backpressure.
- omux_req_o  out  1  request to the multiplexer
- omux_sel_i  in  1  select from the multiplexer. The byte is consumed at this rising edge.
- omux_data_o  out  8  current byte. Valid whenever omux_req_o is high.
- fill_o  out  $clog2(DEPTH)+1  records stored, including the partly sent head record
- full_o  out  1  fill_o == DEPTH
- lost_count_o  out  16  records dropped on overflow, saturating
- lost_clr_i  in  1  synchronous clear of lost_count_o

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream): all of the following go to 0:
  - FIFO pointers and fill_o
  - byte index
  - burst counter
  - yield flag
  - lost_count_o
  - omux_req_o
  - full_o
  - omux_data_o
- Enqueue:
  - If rec_valid_i && !full_o, write to the tail. fill_o increments on the next edge unless a pop happens in the same cycle.
  - If rec_valid_i && full_o, the record is dropped and lost_count_o increments, saturating at 16'hFFFF.
  - full_o is evaluated on registered fill. A push while full is dropped even if a pop occurs in the same cycle.
- lost_clr_i has priority over a simultaneous increment; the result is 0.
- omux_req_o = (fill_o != 0) && !yield. It is combinational from registers and has no dependence on omux_sel_i.
- omux_data_o = byte[idx] of the head record, taken combinationally from FIFO storage and idx.
- Consume occurs on every edge where omux_sel_i && omux_req_o:
  - If idx < REC_BYTES-1: idx++.
  - Otherwise: idx <= 0, pop the head, burst_cnt++.
- Yield rules:
  - When BURST_RECS != 0 and a pop brings burst_cnt to BURST_RECS, set yield and clear burst_cnt.
  - While yield is set, omux_req_o is 0.
  - Yield clears on the edge after omux_sel_i is sampled high with omux_req_o low. That is the multiplexer's release cycle, after which it returns to idle and re-arbitrates.
  - Yield also clears if fill_o reaches 0.
- burst_cnt clears whenever omux_req_o is low for a cycle.
- A byte consumed with REC_BYTES == 1 pops immediately, so idx stays 0.
- Records are never split across grants. The request drops only at a record boundary: either by yield or because the FIFO is empty.
- Timing margin:
  - The multiplexer holds select at most one cycle per byte, then waits for the FT2232 ack.
  - omux_req_o therefore updates one cycle after the last pop, which is ahead of the next select.
- Pointer wrap is modulo DEPTH via the natural pointer width. fill uses one extra bit to distinguish full from empty.
- omux_sel_i high while omux_req_o is low never consumes data.
- Reset in the middle of a record discards the partial record. No bytes are resent.

Decomposition:
- Shared package host_iface_pkg holds:
  - the default REC_BYTES
  - LOST_CNT_W = 16
  - the byte-order convention constant
- One natural sub-module, sync_fifo:
  - parameters WIDTH and DEPTH
  - push/pop interface, with fill, full and empty outputs and head data read combinationally
  - the same clock and reset convention as this block
- The byte index, burst/yield logic and lost counter stay in omux_record_writer.

Test Plan:
- Single record 0x0102_0304_0506 pushed, with a multiplexer model giving select every 3 cycles:
  - omux_data_o sequence is 01,02,03,04,05,06.
  - omux_req_o falls the cycle after the 6th select.
  - fill_o returns from 1 to 0.
- 20 records pushed back-to-back with DEPTH=16 and the multiplexer stalled:
  - full_o is high after 16 records.
  - lost_count_o = 4.
  - The 16 stored records are drained in order, byte-exact.
- Push while full in the same cycle as the final-byte pop:
  - The record is dropped and lost_count_o increments.
  - fill_o goes from 16 to 15.
- BURST_RECS=2 with 5 records queued:
  - omux_req_o drops after the 12th byte.
  - It stays low through exactly one select pulse, then reasserts.
  - Groups of 2, 2 and 1 records are sent, with no record split.
- reset_ni pulsed low mid-record (after 3 bytes sent):
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, an empty FIFO gives no request.
  - A new record restarts at byte 0.
- lost_count_o preloaded to 0xFFFF by 65,535+ overflows, then a further overflow occurs together with lost_clr_i:
  - The count stays at 0xFFFF while it is saturated.
  - A clear in the same cycle as an increment gives 0.
